// File: rtl/wb_ahbl_bridge.sv
// Wishbone-classic slave to AHB-Lite master bridge: each WB cycle becomes one
// SINGLE/NONSEQ AHB transfer, with byte-lane to hsize mapping and error return.
module wb_ahbl_bridge #(
    parameter int ADDR_W         = 32,
    parameter bit ERR_ON_BAD_SEL = 1'b1
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic [ADDR_W-1:0] wb_m2s_adr,
    input  logic [31:0]       wb_m2s_dat,
    input  logic [3:0]        wb_m2s_sel,
    input  logic              wb_m2s_we,
    input  logic              wb_m2s_cyc,
    input  logic              wb_m2s_stb,
    output logic [31:0]       wb_s2m_dat,
    output logic              wb_s2m_ack,
    output logic              wb_s2m_err,
    output logic              hclk,
    output logic              hresetn,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [1:0]        htrans,
    output logic [31:0]       hwdata,
    input  logic [31:0]       hrdata,
    input  logic              hready,
    input  logic [1:0]        hresp
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] haddr_q, haddr_nx;
    logic              hwrite_q, hwrite_nx;
    logic [2:0]        hsize_q, hsize_nx;
    logic [31:0]       hwdata_q, hwdata_nx;
    logic [31:0]       rdata_q, rdata_nx;
    logic              resp_err_q, resp_err_nx;
    logic              aborted_q, aborted_nx;

    logic              sel_ok;
    logic [2:0]        dec_size;
    logic [1:0]        dec_lo;
    logic              req;
    logic              unused_inputs;

    assign unused_inputs = ^{wb_m2s_adr[1:0], hresp[1]};

    assign hclk       = wb_clk;
    assign hresetn    = ~wb_rst;
    assign hburst     = 3'b000;
    assign htrans     = (state == ADDR) ? 2'b10 : 2'b00;
    assign haddr      = haddr_q;
    assign hwrite     = hwrite_q;
    assign hsize      = hsize_q;
    assign hwdata     = hwdata_q;
    assign wb_s2m_dat = rdata_q;
    assign wb_s2m_ack = (state == RESP) && !resp_err_q;
    assign wb_s2m_err = (state == RESP) && resp_err_q;

    assign req = wb_m2s_cyc & wb_m2s_stb & ~wb_s2m_ack & ~wb_s2m_err;

    // Unsupported lane patterns fall back to a word transfer at the aligned address.
    always_comb begin
        sel_ok   = 1'b1;
        dec_size = 3'd2;
        dec_lo   = 2'b00;
        case (wb_m2s_sel)
            4'b1111: begin dec_size = 3'd2; dec_lo = 2'b00; end
            4'b0011: begin dec_size = 3'd1; dec_lo = 2'b00; end
            4'b1100: begin dec_size = 3'd1; dec_lo = 2'b10; end
            4'b0001: begin dec_size = 3'd0; dec_lo = 2'b00; end
            4'b0010: begin dec_size = 3'd0; dec_lo = 2'b01; end
            4'b0100: begin dec_size = 3'd0; dec_lo = 2'b10; end
            4'b1000: begin dec_size = 3'd0; dec_lo = 2'b11; end
            default: sel_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nx    = state;
        haddr_nx    = haddr_q;
        hwrite_nx   = hwrite_q;
        hsize_nx    = hsize_q;
        hwdata_nx   = hwdata_q;
        rdata_nx    = rdata_q;
        resp_err_nx = resp_err_q;
        aborted_nx  = aborted_q;
        case (state)
            IDLE: begin
                if (req) begin
                    if (sel_ok || !ERR_ON_BAD_SEL) begin
                        state_nx   = ADDR;
                        haddr_nx   = {wb_m2s_adr[ADDR_W-1:2], dec_lo};
                        hwrite_nx  = wb_m2s_we;
                        hsize_nx   = dec_size;
                        aborted_nx = 1'b0;
                    end else begin
                        state_nx    = RESP;
                        resp_err_nx = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (!wb_m2s_cyc) aborted_nx = 1'b1;
                if (hready) begin
                    state_nx  = DATA;
                    hwdata_nx = wb_m2s_dat;
                end
            end
            DATA: begin
                // A dropped cycle still lets the AHB transfer finish, but the WB side gets no response.
                if (!wb_m2s_cyc) aborted_nx = 1'b1;
                if (hready) begin
                    if (aborted_nx) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx    = RESP;
                        resp_err_nx = hresp[0];
                        if (!hresp[0] && !hwrite_q) rdata_nx = hrdata;
                    end
                end
            end
            RESP: begin
                state_nx    = IDLE;
                resp_err_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state      <= IDLE;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hsize_q    <= 3'b010;
            hwdata_q   <= '0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            haddr_q    <= haddr_nx;
            hwrite_q   <= hwrite_nx;
            hsize_q    <= hsize_nx;
            hwdata_q   <= hwdata_nx;
            rdata_q    <= rdata_nx;
            resp_err_q <= resp_err_nx;
            aborted_q  <= aborted_nx;
        end
    end

endmodule

// File: tb/tb_wb_ahbl_bridge.sv
// Scoreboarded bench for wb_ahbl_bridge: a WB driver queues expectations, an AHB
// slave model plays planned wait/error responses, and a WB monitor checks replies.
module tb_wb_ahbl_bridge;

    localparam int ADDR_W         = 32;
    localparam bit ERR_ON_BAD_SEL = 1'b1;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] wb_m2s_adr, wb_m2s_dat;
    logic [3:0]  wb_m2s_sel;
    logic        wb_m2s_we, wb_m2s_cyc, wb_m2s_stb;
    logic [31:0] wb_s2m_dat;
    logic        wb_s2m_ack, wb_s2m_err;
    logic        hclk, hresetn, hwrite;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans, hresp;
    logic        hready;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        int          aw;
        int          dw;
        bit          is_err;
        logic [31:0] rdata;
    } ahb_plan_t;

    typedef struct {
        bit          is_err;
        logic [31:0] dat;
    } wb_exp_t;

    typedef struct {
        bit          rdy;
        bit          herr;
        logic [31:0] rdata;
        bit          write;
        logic [31:0] wdata;
    } beat_t;

    ahb_plan_t   plan_q[$];
    wb_exp_t     wbexp_q[$];
    beat_t       play_q[$];
    logic [31:0] last_rdata = '0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          aw_cnt = 0;

    wb_ahbl_bridge #(.ADDR_W(ADDR_W), .ERR_ON_BAD_SEL(ERR_ON_BAD_SEL)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wb_m2s_adr(wb_m2s_adr), .wb_m2s_dat(wb_m2s_dat), .wb_m2s_sel(wb_m2s_sel),
        .wb_m2s_we(wb_m2s_we), .wb_m2s_cyc(wb_m2s_cyc), .wb_m2s_stb(wb_m2s_stb),
        .wb_s2m_dat(wb_s2m_dat), .wb_s2m_ack(wb_s2m_ack), .wb_s2m_err(wb_s2m_err),
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference lane decode: contiguous naturally aligned lane groups of 1, 2 or 4 bytes.
    function automatic bit ref_decode(input logic [3:0] s, input logic [31:0] a,
                                      output logic [2:0] size, output logic [31:0] addr);
        int n;
        int low;
        bit ok;
        n   = $countones(s);
        low = 0;
        for (int i = 3; i >= 0; i--) if (s[i]) low = i;
        ok = (n == 1) || (n == 4) || (n == 2 && (low % 2 == 0) && s[low+1]);
        if (ok) begin
            size = (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : 3'd2;
            addr = {a[31:2], 2'b00} + low;
        end else begin
            size = 3'd2;
            addr = {a[31:2], 2'b00};
        end
        return ok;
    endfunction

    function automatic ahb_plan_t make_plan(input logic [31:0] ha, input logic [2:0] sz, input logic w,
                                            input logic [31:0] d, input int aw, input int dw,
                                            input bit e, input logic [31:0] rd);
        ahb_plan_t p;
        p.addr = ha; p.size = sz; p.write = w; p.wdata = d;
        p.aw = aw; p.dw = dw; p.is_err = e; p.rdata = rd;
        return p;
    endfunction

    task automatic drive_wb(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        wb_m2s_adr = a; wb_m2s_dat = d; wb_m2s_sel = s; wb_m2s_we = w;
        wb_m2s_cyc = 1'b1; wb_m2s_stb = 1'b1;
    endtask

    task automatic bus_idle();
        wb_m2s_cyc = 1'b0; wb_m2s_stb = 1'b0; wb_m2s_we = 1'b0; wb_m2s_sel = 4'h0;
        @(negedge wb_clk);
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                  input logic w, input int aw, input int dw, input bit e,
                                  input logic [31:0] rd);
        logic [2:0]  sz;
        logic [31:0] ha;
        wb_exp_t     x;
        int          exp_lat;
        int          cycles;
        if (!ref_decode(s, a, sz, ha) && ERR_ON_BAD_SEL) begin
            x.is_err = 1'b1;
            x.dat    = last_rdata;
            exp_lat  = 1;
        end else begin
            plan_q.push_back(make_plan(ha, sz, w, d, aw, dw, e, rd));
            x.is_err = e;
            x.dat    = (!w && !e) ? rd : last_rdata;
            exp_lat  = 3 + aw + dw + (e ? 1 : 0);
        end
        last_rdata = x.dat;
        wbexp_q.push_back(x);
        drive_wb(a, d, s, w);
        cycles = 0;
        do begin
            @(negedge wb_clk);
            cycles++;
        end while (!(wb_s2m_ack || wb_s2m_err) && cycles < 40);
        check_output("latency", cycles, exp_lat);
        @(negedge wb_clk);
        check_output("ack_one_cycle", wb_s2m_ack, 1'b0);
        check_output("err_one_cycle", wb_s2m_err, 1'b0);
        check_output("htrans_idle_after_resp", htrans, 2'b00);
    endtask

    task automatic check_reset_values();
        check_output("rst_htrans", htrans, 2'b00);
        check_output("rst_haddr", haddr, 32'h0);
        check_output("rst_hwrite", hwrite, 1'b0);
        check_output("rst_hsize", hsize, 3'b010);
        check_output("rst_hwdata", hwdata, 32'h0);
        check_output("rst_wb_dat", wb_s2m_dat, 32'h0);
        check_output("rst_ack", wb_s2m_ack, 1'b0);
        check_output("rst_err", wb_s2m_err, 1'b0);
        check_output("rst_hresetn", hresetn, 1'b0);
        check_output("hburst_single", hburst, 3'b000);
    endtask

    // AHB slave model: replays the planned address stalls, data waits and two-cycle ERROR.
    initial begin
        ahb_plan_t p;
        beat_t     b;
        hready = 1'b1; hresp = 2'b00; hrdata = '0;
        forever begin
            @(negedge wb_clk);
            if (wb_rst) begin
                play_q.delete();
                aw_cnt = 0;
                hready = 1'b1; hresp = 2'b00;
            end else if (play_q.size() > 0) begin
                b = play_q.pop_front();
                hready = b.rdy;
                hresp  = {1'($urandom_range(0, 1)), b.herr};
                hrdata = b.rdata;
                check_output("htrans_idle_in_data", htrans, 2'b00);
                if (b.write) check_output("hwdata_stable", hwdata, b.wdata);
            end else if (htrans == 2'b10) begin
                if (plan_q.size() == 0) begin
                    check_output("nonseq_expected", plan_q.size(), 1);
                    hready = 1'b1;
                end else begin
                    p = plan_q[0];
                    check_output("haddr", haddr, p.addr);
                    check_output("hsize", hsize, p.size);
                    check_output("hwrite", hwrite, p.write);
                    hresp = 2'b00;
                    if (aw_cnt < p.aw) begin
                        hready = 1'b0;
                        aw_cnt++;
                    end else begin
                        hready = 1'b1;
                        aw_cnt = 0;
                        void'(plan_q.pop_front());
                        for (int i = 0; i < p.dw; i++)
                            play_q.push_back('{1'b0, 1'b0, $urandom, p.write, p.wdata});
                        if (p.is_err) begin
                            play_q.push_back('{1'b0, 1'b1, $urandom, p.write, p.wdata});
                            play_q.push_back('{1'b1, 1'b1, $urandom, p.write, p.wdata});
                        end else begin
                            play_q.push_back('{1'b1, 1'b0, p.rdata, p.write, p.wdata});
                        end
                    end
                end
            end else begin
                hready = 1'b1;
                hresp  = {1'($urandom_range(0, 1)), 1'b0};
            end
        end
    end

    // WB monitor: every ack/err must match the oldest outstanding expectation.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge wb_clk);
            if (wb_s2m_ack || wb_s2m_err) begin
                check_output("ack_err_exclusive", wb_s2m_ack & wb_s2m_err, 1'b0);
                if (wbexp_q.size() == 0) begin
                    check_output("response_expected", wbexp_q.size(), 1);
                end else begin
                    e = wbexp_q.pop_front();
                    check_output("resp_is_err", wb_s2m_err, e.is_err);
                    check_output("wb_dat", wb_s2m_dat, e.dat);
                end
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        bit          seen;
        logic [3:0]  sel_pool [0:9];
        logic [3:0]  s;
        logic [31:0] last_before;
        wb_rst = 1'b1;
        wb_m2s_adr = '0; wb_m2s_dat = '0; wb_m2s_sel = '0;
        wb_m2s_we = 1'b0; wb_m2s_cyc = 1'b0; wb_m2s_stb = 1'b0;
        sel_pool = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010,
                     4'b0100, 4'b1000, 4'b0101, 4'b0110, 4'b1110};
        repeat (3) @(negedge wb_clk);
        check_reset_values();
        wb_rst = 1'b0;
        @(negedge wb_clk);
        $display("[TB] directed transfers");

        apply_stimulus(32'h4000_0010, 32'h0, 4'b1111, 1'b0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        bus_idle();
        apply_stimulus(32'h4000_0020, 32'h00AB_0000, 4'b0100, 1'b1, 0, 2, 1'b0, 32'h0);
        bus_idle();
        apply_stimulus(32'h4000_0030, 32'h1234_5678, 4'b1111, 1'b1, 0, 0, 1'b1, 32'h0);
        bus_idle();
        apply_stimulus(32'h4000_0040, 32'h0, 4'b0101, 1'b0, 0, 0, 1'b0, 32'h0);
        bus_idle();

        // Reset while the data phase is stalled; the pending read must vanish silently.
        plan_q.push_back(make_plan(32'h4000_0050, 3'd2, 1'b0, 32'h0, 0, 6, 1'b0, 32'hCAFE_0001));
        wbexp_q.push_back('{1'b0, 32'hCAFE_0001});
        drive_wb(32'h4000_0050, 32'h0, 4'b1111, 1'b0);
        repeat (3) @(negedge wb_clk);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        check_reset_values();
        wbexp_q.delete();
        last_rdata = '0;
        wb_m2s_cyc = 1'b0; wb_m2s_stb = 1'b0;
        @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        apply_stimulus(32'h4000_0060, 32'h0, 4'b1111, 1'b0, 0, 0, 1'b0, 32'h1357_9BDF);
        bus_idle();

        // Back-to-back reads with stb held high between them.
        apply_stimulus(32'h4000_0070, 32'h0, 4'b1111, 1'b0, 0, 0, 1'b0, 32'hA5A5_0001);
        apply_stimulus(32'h4000_0074, 32'h0, 4'b0011, 1'b0, 1, 1, 1'b0, 32'h5A5A_0002);
        bus_idle();

        // cyc dropped mid data phase: transfer completes on AHB, no WB response.
        plan_q.push_back(make_plan(32'h4000_0080, 3'd2, 1'b1, 32'h7777_8888, 0, 3, 1'b0, 32'h0));
        drive_wb(32'h4000_0080, 32'h7777_8888, 4'b1111, 1'b1);
        repeat (2) @(negedge wb_clk);
        wb_m2s_cyc = 1'b0; wb_m2s_stb = 1'b0;
        seen = 1'b0;
        last_before = wb_s2m_dat;
        repeat (8) begin
            @(negedge wb_clk);
            if (wb_s2m_ack || wb_s2m_err) seen = 1'b1;
        end
        check_output("abort_no_response", seen, 1'b0);
        check_output("abort_ahb_done", plan_q.size(), 0);
        check_output("abort_dat_kept", wb_s2m_dat, last_before);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 60; t++) begin
            s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : sel_pool[$urandom_range(0, 9)];
            apply_stimulus($urandom, $urandom, s, 1'($urandom_range(0, 1)),
                           $urandom_range(0, 2), $urandom_range(0, 3),
                           ($urandom_range(0, 4) == 0), $urandom);
            if ($urandom_range(0, 2) == 0) bus_idle();
        end
        bus_idle();
        repeat (2) @(negedge wb_clk);

        check_output("pending_wb_responses", wbexp_q.size(), 0);
        check_output("pending_ahb_transfers", plan_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ahbl_bridge.md
Name: wb_ahbl_bridge

Overview:
- Wishbone-classic slave to AHB-Lite master bridge, one outstanding transfer at a time.
- Sits directly downstream of the SoC Wishbone master port (wb_m2s_*/wb_s2m_*) and drives the AHB-Lite peripheral bus (haddr/htrans/hwdata/hrdata...).
- Converts single WB cycles into single NONSEQ AHB transfers, including byte-lane to hsize mapping and error propagation.

Parameters:
- ADDR_W, 32, address width on both buses.
- ERR_ON_BAD_SEL, 1, 1 = unsupported wb sel pattern answered with wb_s2m_err and no AHB transfer; 0 = issued as word transfer.

Ports:
- wb_clk  in  1  single clock for WB and AHB sides.
- wb_rst  in  1  synchronous active-high reset.
- wb_m2s_adr  in  ADDR_W  WB address.
- wb_m2s_dat  in  32  WB write data.
- wb_m2s_sel  in  4  WB byte selects.
- wb_m2s_we  in  1  WB write enable.
- wb_m2s_cyc  in  1  WB cycle.
- wb_m2s_stb  in  1  WB strobe.
- wb_s2m_dat  out  32  WB read data (registered).
- wb_s2m_ack  out  1  WB acknowledge, one-cycle pulse.
- wb_s2m_err  out  1  WB error, one-cycle pulse.
- hclk  out  1  equals wb_clk.
- hresetn  out  1  equals ~wb_rst.
- haddr  out  ADDR_W  AHB address.
- hwrite  out  1  AHB write.
- hsize  out  3  0=byte, 1=half, 2=word.
- hburst  out  3  constant 3'b000 (SINGLE).
- htrans  out  2  2'b00 IDLE, 2'b10 NONSEQ only.
- hwdata  out  32  AHB write data, valid in data phase.
- hrdata  in  32  AHB read data.
- hready  in  1  AHB ready.
- hresp  in  2  bit0 = ERROR; bit1 ignored.

Behaviour:
- Reset (wb_rst sampled high at posedge): state IDLE; htrans=00, haddr=0, hwrite=0, hsize=010, hwdata=0, wb_s2m_dat=0, wb_s2m_ack=0, wb_s2m_err=0. Reset mid-transfer abandons it, no ack/err issued.
- States: IDLE, ADDR, DATA, RESP.
- IDLE: on cyc&stb&~ack&~err -> decode sel; valid -> ADDR, registering haddr/hwrite/hsize, htrans=NONSEQ; invalid with ERR_ON_BAD_SEL=1 -> RESP with err.
- Sel decode: 1111 -> word, haddr[1:0]=00; 0011 -> half, +0; 1100 -> half, +2; 0001/0010/0100/1000 -> byte, +0/+1/+2/+3; all others invalid. haddr upper bits = wb_m2s_adr[ADDR_W-1:2].
- ADDR (one cycle, htrans=NONSEQ): if hready high -> DATA with htrans=IDLE and hwdata=wb_m2s_dat; if hready low, hold NONSEQ and all address signals stable.
- DATA: wait for hready=1. hresp[0]=0 -> capture hrdata into wb_s2m_dat (reads only), assert ack. hresp[0]=1 (first ERROR cycle, hready=0) -> keep htrans IDLE, complete on second cycle (hready=1) and assert err. hwdata held stable throughout.
- RESP: ack or err high exactly one cycle, then IDLE. Next request accepted no earlier than the cycle after ack/err deasserts.
- Latency with zero-wait slave: stb seen at edge N -> NONSEQ cycle N..N+1 -> data phase N+1..N+2 -> ack high N+2..N+3. Total 3 cycles.
- cyc dropped during ADDR/DATA: AHB transfer completes normally; ack/err suppressed; return to IDLE.
- ack and err never high together; wb_s2m_dat unchanged on writes and errors.

Test Plan:
- Word read, zero-wait: adr=0x4000_0010, sel=1111, we=0, hrdata=0xDEADBEEF -> one NONSEQ with haddr=0x4000_0010, hsize=2, hwrite=0; ack 3 cycles after stb, wb_s2m_dat=0xDEADBEEF.
- Byte write with 2 wait states: adr=0x4000_0020, sel=0100, dat=0x00AB0000, hready low 2 data cycles -> haddr=0x4000_0022, hsize=0, hwdata=0x00AB0000 stable; ack at cycle 5.
- AHB error: word write, slave gives two-cycle ERROR -> err pulse one cycle, ack stays 0, htrans IDLE during error cycles.
- Bad sel: sel=0101 with ERR_ON_BAD_SEL=1 -> err one cycle later, htrans never leaves IDLE.
- Reset mid-transfer: assert wb_rst while in DATA with hready low -> next edge all outputs at reset values, no ack/err; subsequent read completes normally.
- Back-to-back: two reads with stb held high and new adr after ack -> two separate NONSEQ transfers, one IDLE cycle between ack and next NONSEQ, correct data per read.
